cpu_io_bridge: RTL and testbench

CPU_IO_BRIDGE -- requirements
Module: cpu_io_bridge

---
 rtl/cpu_io_bridge.sv | 232 +++++++++++++++++++++++
 tb/tb_cpu_io_bridge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge
//   Bridges an asynchronous CPU strobe interface onto a clocked VDP
//   request/acknowledge port. The raw strobes are synchronised and
//   glitch-filtered. CPU writes are buffered, and a single CPU read is held
//   pending until all buffered writes have drained.
//
//   Build option: define CPU_IO_WRITE_FIFO_EN to get a FIFO_DEPTH-entry write
//   FIFO. Without it, the write buffer is a single holding register.
//
// Ports
//   clk       pixel clock; all state changes on its rising edge
//   reset     asynchronous, active-high
//   csr_n     raw CPU read strobe, active low, asynchronous to clk
//   csw_n     raw CPU write strobe, active low, asynchronous to clk
//   mode      CPU port-select address lines
//   cd_in     CPU write data
//   cd_out    last read data returned by the VDP
//   cd_oe     CPU bus output enable
//   req       VDP request (registered)
//   wrt       1 = write request, 0 = read request
//   adr       VDP port address
//   dbo       VDP write data
//   ack       VDP acknowledge, one-cycle pulse
//   dbi       VDP read data, valid while ack = 1
//   overflow  sticky flag: a CPU write was dropped because the buffer was full
module cpu_io_bridge #(
    parameter int ADDR_BITS  = 2,
    parameter int FILTER_LEN = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 csr_n,
    input  logic                 csw_n,
    input  logic [ADDR_BITS-1:0] mode,
    input  logic [7:0]           cd_in,
    output logic [7:0]           cd_out,
    output logic                 cd_oe,
    output logic                 req,
    output logic                 wrt,
    output logic [ADDR_BITS-1:0] adr,
    output logic [7:0]           dbo,
    input  logic                 ack,
    input  logic [7:0]           dbi,
    output logic                 overflow
);

    localparam int CW      = $clog2(FILTER_LEN + 1);
    localparam int ENTRY_W = ADDR_BITS + 8;

`ifdef CPU_IO_WRITE_FIFO_EN
    localparam int BUF_DEPTH = FIFO_DEPTH;
`else
    // FIFO_DEPTH has no effect in this build; the buffer holds one entry.
    localparam int BUF_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ} state_t;

    // ------------------------------------------------------------------
    // Strobe synchronisers and filters. Index 0 is csr_n, index 1 is csw_n.
    // ------------------------------------------------------------------
    logic [1:0]    raw;
    logic [1:0]    s1, s2;
    logic [1:0]    filt, filt_d;
    logic [1:0]    armed;
    logic [1:0]    live;
    logic [CW-1:0] fcnt [2];
    logic [1:0]    fall;
    logic          wr_access, rd_access;

    assign raw = {csw_n, csr_n};

    // live[1] marks the first cycle in which s2 holds a real pin sample
    // rather than its reset value. armed[i] is set once strobe i is seen
    // high after that point. As a result, a strobe that is already low when
    // reset is released does not count as an access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1     <= '1;
            s2     <= '1;
            filt   <= '1;
            filt_d <= '1;
            armed  <= '0;
            live   <= '0;
            for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            filt_d <= filt;
            live   <= {live[0], 1'b1};
            for (int unsigned i = 0; i < 2; i++) begin
                armed[i] <= armed[i] | (live[1] & s2[i]);
                // Count consecutive samples that differ from the filtered
                // level. The level follows the samples on the FILTER_LEN-th one.
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + CW'(1);
                end
            end
        end
    end

    assign fall      = filt_d & ~filt & armed;
    assign wr_access = fall[1] & filt[0];
    assign rd_access = fall[0] & filt[1];
    assign cd_oe     = ~filt[0] & filt[1];

    // ------------------------------------------------------------------
    // Write buffer
    // ------------------------------------------------------------------
    state_t               state;
    logic [CNT_W-1:0]     count;
    logic                 empty, full, pop, push_ok;
    logic [ENTRY_W-1:0]   entry, head;

    assign entry   = {mode, cd_in};
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(BUF_DEPTH));
    assign pop     = (state == WR_REQ) & ack;
    // While full, a push is accepted only if the head is leaving in the
    // same cycle.
    assign push_ok = wr_access & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push_ok) count <= count - CNT_W'(1);
            if (wr_access && full && !pop) overflow <= 1'b1;
        end
    end

`ifdef CPU_IO_WRITE_FIFO_EN
    localparam int PTR_W = $clog2(BUF_DEPTH);

    logic [ENTRY_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]   wptr, rptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_W'(1);
            if (pop)     rptr <= rptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= entry;
    end

    assign head = mem[rptr];
`else
    logic [ENTRY_W-1:0] hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        hold <= '0;
        else if (push_ok) hold <= entry;
    end

    assign head = hold;
`endif

    // ------------------------------------------------------------------
    // Request FSM with registered outputs
    // ------------------------------------------------------------------
    logic                 rd_pend;
    logic [ADDR_BITS-1:0] rd_adr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            req     <= 1'b0;
            wrt     <= 1'b0;
            adr     <= '0;
            dbo     <= '0;
            cd_out  <= '0;
            rd_pend <= 1'b0;
            rd_adr  <= '0;
        end else begin
            // A new read replaces any read that is still waiting.
            if (rd_access) begin
                rd_pend <= 1'b1;
                rd_adr  <= mode;
            end
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= WR_REQ;
                        req   <= 1'b1;
                        wrt   <= 1'b1;
                        adr   <= head[ENTRY_W-1:8];
                        dbo   <= head[7:0];
                    end else if (rd_pend) begin
                        state <= RD_REQ;
                        req   <= 1'b1;
                        wrt   <= 1'b0;
                        adr   <= rd_adr;
                    end
                end
                WR_REQ: begin
                    if (ack) begin
                        state <= IDLE;
                        req   <= 1'b0;
                    end
                end
                RD_REQ: begin
                    if (ack) begin
                        state  <= IDLE;
                        req    <= 1'b0;
                        cd_out <= dbi;
                        if (!rd_access) rd_pend <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Self-checking testbench for cpu_io_bridge (ADDR_BITS=2, FILTER_LEN=3,
// FIFO_DEPTH=4). Inputs are driven on the falling clock edge, and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_cpu_io_bridge;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       csr_n = 1'b1;
    logic       csw_n = 1'b1;
    logic [1:0] mode  = '0;
    logic [7:0] cd_in = '0;
    logic [7:0] cd_out;
    logic       cd_oe;
    logic       req;
    logic       wrt;
    logic [1:0] adr;
    logic [7:0] dbo;
    logic       ack   = 1'b0;
    logic [7:0] dbi   = '0;
    logic       overflow;

    int tests = 0;
    int fails = 0;

`ifdef CPU_IO_WRITE_FIFO_EN
    localparam int NEXP = 4;
`else
    localparam int NEXP = 1;
`endif

    cpu_io_bridge #(.ADDR_BITS(2), .FILTER_LEN(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .csr_n(csr_n), .csw_n(csw_n), .mode(mode),
        .cd_in(cd_in), .cd_out(cd_out), .cd_oe(cd_oe), .req(req), .wrt(wrt),
        .adr(adr), .dbo(dbo), .ack(ack), .dbi(dbi), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; csr_n = 1'b1; csw_n = 1'b1; ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        mode = a; cd_in = d; csw_n = 1'b0;
        repeat (8) tick();
        csw_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic wait_req(input int maxc, output bit seen);
        seen = (req === 1'b1);
        for (int i = 0; i < maxc && !seen; i++) begin
            tick();
            seen = (req === 1'b1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", req); end
        tests++; if (wrt !== 1'b0) begin fails++; $display("FAIL reset_wrt: got %b want 0", wrt); end
        tests++; if (adr !== 2'd0) begin fails++; $display("FAIL reset_adr: got %0d want 0", adr); end
        tests++; if (dbo !== 8'h00) begin fails++; $display("FAIL reset_dbo: got %h want 00", dbo); end
        tests++; if (cd_out !== 8'h00) begin fails++; $display("FAIL reset_cd_out: got %h want 00", cd_out); end
        tests++; if (cd_oe !== 1'b0) begin fails++; $display("FAIL reset_cd_oe: got %b want 0", cd_oe); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        reset = 1'b0;
        repeat (6) tick();
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL reset_idle_req: got %b want 0", req); end
    endtask

    task automatic test_single_write();
        int  cyc;
        bit  extra;
        do_reset();
        mode = 2'd1; cd_in = 8'h5A; csw_n = 1'b0;
        cyc = 0;
        while (req !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        // 2 sync + 3 filter samples + 2 cycles edge-to-req
        tests++; if (cyc != 7) begin fails++; $display("FAIL write_latency: got %0d cycles want 7", cyc); end
        tests++; if (wrt !== 1'b1) begin fails++; $display("FAIL write_wrt: got %b want 1", wrt); end
        tests++; if (adr !== 2'd1) begin fails++; $display("FAIL write_adr: got %0d want 1", adr); end
        tests++; if (dbo !== 8'h5A) begin fails++; $display("FAIL write_dbo: got %h want 5a", dbo); end
        repeat (3) tick();
        tests++; if (req !== 1'b1 || dbo !== 8'h5A) begin fails++; $display("FAIL write_hold: got req=%b dbo=%h want req=1 dbo=5a", req, dbo); end
        ack = 1'b1; tick(); ack = 1'b0;
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL write_req_drop: got %b want 0", req); end
        csw_n = 1'b1;
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); if (req !== 1'b0) extra = 1'b1; end
        tests++; if (extra) begin fails++; $display("FAIL write_single_req: got extra req want none"); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL write_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_glitch();
        bit extra;
        do_reset();
        mode = 2'd2; cd_in = 8'hEE;
        csw_n = 1'b0; tick(); tick(); csw_n = 1'b1;
        extra = 1'b0;
        for (int i = 0; i < 15; i++) begin tick(); if (req !== 1'b0) extra = 1'b1; end
        tests++; if (extra) begin fails++; $display("FAIL glitch_req: got req=1 want 0"); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL glitch_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        bit         seen;
        bit         extra;
        logic [1:0] ea;
        do_reset();
        for (int i = 1; i <= 5; i++) cpu_write(2'(i & 3), 8'(i));
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        for (int k = 0; k < NEXP; k++) begin
            ea = 2'((k + 1) & 3);
            wait_req(30, seen);
            tests++; if (!seen) begin fails++; $display("FAIL ovf_req%0d: got no req want req", k); end
            tests++; if (wrt !== 1'b1 || dbo !== 8'(k + 1) || adr !== ea)
                begin fails++; $display("FAIL ovf_entry%0d: got wrt=%b adr=%0d dbo=%h want wrt=1 adr=%0d dbo=%h", k, wrt, adr, dbo, ea, 8'(k + 1)); end
            ack = 1'b1; tick(); ack = 1'b0;
        end
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); if (req !== 1'b0) extra = 1'b1; end
        tests++; if (extra) begin fails++; $display("FAIL ovf_extra: got extra req want none"); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_write_then_read();
        bit seen;
        do_reset();
        cpu_write(2'd3, 8'h11);
        mode = 2'd0; csr_n = 1'b0;
        repeat (8) tick();
        wait_req(30, seen);
        tests++; if (!seen || wrt !== 1'b1 || dbo !== 8'h11 || adr !== 2'd3)
            begin fails++; $display("FAIL wr_first: got req=%b wrt=%b adr=%0d dbo=%h want req=1 wrt=1 adr=3 dbo=11", req, wrt, adr, dbo); end
        ack = 1'b1; tick(); ack = 1'b0;
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL wr_first_drop: got %b want 0", req); end
        wait_req(30, seen);
        tests++; if (!seen || wrt !== 1'b0 || adr !== 2'd0)
            begin fails++; $display("FAIL rd_second: got req=%b wrt=%b adr=%0d want req=1 wrt=0 adr=0", req, wrt, adr); end
        dbi = 8'hA5; ack = 1'b1; tick(); ack = 1'b0; dbi = 8'h00;
        tests++; if (cd_out !== 8'hA5) begin fails++; $display("FAIL rd_data: got %h want a5", cd_out); end
        tests++; if (cd_oe !== 1'b1) begin fails++; $display("FAIL rd_oe: got %b want 1", cd_oe); end
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL rd_drop: got %b want 0", req); end
        csr_n = 1'b1;
        repeat (8) tick();
        tests++; if (cd_oe !== 1'b0) begin fails++; $display("FAIL rd_oe_off: got %b want 0", cd_oe); end
        tests++; if (cd_out !== 8'hA5) begin fails++; $display("FAIL rd_data_hold: got %h want a5", cd_out); end
    endtask

    task automatic test_both_low();
        bit any_req, any_oe;
        do_reset();
        mode = 2'd1; cd_in = 8'h99;
        csr_n = 1'b0; csw_n = 1'b0;
        any_req = 1'b0; any_oe = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (req !== 1'b0) any_req = 1'b1;
            if (cd_oe !== 1'b0) any_oe = 1'b1;
        end
        csr_n = 1'b1; csw_n = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); if (req !== 1'b0) any_req = 1'b1; end
        tests++; if (any_req) begin fails++; $display("FAIL both_req: got req=1 want 0"); end
        tests++; if (any_oe) begin fails++; $display("FAIL both_oe: got cd_oe=1 want 0"); end
    endtask

    task automatic test_reset_mid();
        bit seen, extra;
        do_reset();
        cpu_write(2'd2, 8'h77);
        tests++; if (req !== 1'b1) begin fails++; $display("FAIL mid_req_before: got %b want 1", req); end
        reset = 1'b1; tick(); reset = 1'b0;
        tests++; if (req !== 1'b0 || overflow !== 1'b0)
            begin fails++; $display("FAIL mid_after_reset: got req=%b overflow=%b want 0 0", req, overflow); end
        ack = 1'b1; tick(); ack = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); if (req !== 1'b0) extra = 1'b1; end
        tests++; if (extra) begin fails++; $display("FAIL mid_late_ack: got req=1 want 0"); end
        cpu_write(2'd1, 8'h42);
        wait_req(30, seen);
        tests++; if (!seen || dbo !== 8'h42 || adr !== 2'd1)
            begin fails++; $display("FAIL mid_fifo_empty: got req=%b adr=%0d dbo=%h want req=1 adr=1 dbo=42", req, adr, dbo); end
        ack = 1'b1; tick(); ack = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); if (req !== 1'b0) extra = 1'b1; end
        tests++; if (extra) begin fails++; $display("FAIL mid_stale_entry: got extra req want none"); end
    endtask

    task automatic test_low_at_release();
        bit seen, extra;
        reset = 1'b1; csw_n = 1'b0; mode = 2'd3; cd_in = 8'hCC;
        tick(); tick();
        reset = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 15; i++) begin tick(); if (req !== 1'b0) extra = 1'b1; end
        csw_n = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); if (req !== 1'b0) extra = 1'b1; end
        tests++; if (extra) begin fails++; $display("FAIL release_low: got req=1 want 0"); end
        cpu_write(2'd0, 8'h33);
        wait_req(30, seen);
        tests++; if (!seen || dbo !== 8'h33 || adr !== 2'd0)
            begin fails++; $display("FAIL release_next_write: got req=%b adr=%0d dbo=%h want req=1 adr=0 dbo=33", req, adr, dbo); end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_glitch();
        test_overflow();
        test_write_then_read();
        test_both_low();
        test_reset_mid();
        test_low_at_release();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
